// File: rtl/ariane_regfile_sb.sv
// Parametrised flip-flop register file with prioritised write ports, optional
// write-to-read bypass, optional registered reads and a per-register busy scoreboard.
module ariane_regfile_sb #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned NUM_WORDS       = 32,
  parameter int unsigned NR_READ_PORTS   = 2,
  parameter int unsigned NR_WRITE_PORTS  = 2,
  parameter int unsigned ZERO_REG_ZERO   = 1,
  parameter int unsigned BYPASS_EN       = 1,
  parameter int unsigned READ_REGISTERED = 0,
  localparam int unsigned ADDR_WIDTH     = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  test_en_i,
  input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]   rdata_o,
  output logic [NR_READ_PORTS-1:0]              rbusy_o,
  input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]             we_i,
  input  logic                                  alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 alloc_addr_i,
  input  logic                                  flush_i,
  output logic                                  collision_o
);

  localparam logic [ADDR_WIDTH:0] WORDS = (ADDR_WIDTH+1)'(NUM_WORDS);

  logic [DATA_WIDTH-1:0] mem_reg [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_reg;
  logic [NUM_WORDS-1:0]  busy_next;
  logic [NUM_WORDS-1:0]  wr_en;
  logic [DATA_WIDTH-1:0] wr_data [NUM_WORDS];
  logic [NUM_WORDS-1:0]  alloc_hit;
  logic                  collision_reg;
  logic                  collision_next;

  logic [ADDR_WIDTH-1:0] waddr [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata [NR_WRITE_PORTS];

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Out-of-range addresses and (optionally) register 0 are never stored or tracked.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    addr_ok = ({1'b0, a} < WORDS) && !((ZERO_REG_ZERO != 0) && (a == '0));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NR_WRITE_PORTS; gi++) begin : g_wport
      assign waddr[gi] = waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_comb begin
    wr_en = '0;
    for (int r = 0; r < NUM_WORDS; r++) begin
      wr_data[r] = '0;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        if (we_i[p] && (waddr[p] == ADDR_WIDTH'(r)) && addr_ok(waddr[p])) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wdata[p];
        end
      end
    end
  end

  always_comb begin
    collision_next = 1'b0;
    for (int p = 0; p < NR_WRITE_PORTS; p++) begin
      for (int q = p + 1; q < NR_WRITE_PORTS; q++) begin
        if (we_i[p] && we_i[q] && (waddr[p] == waddr[q]) && addr_ok(waddr[p])) begin
          collision_next = 1'b1;
        end
      end
    end
  end

  // A new producer supersedes the one retiring in the same cycle; flush beats both.
  always_comb begin
    alloc_hit = '0;
    busy_next = busy_reg;
    for (int r = 0; r < NUM_WORDS; r++) begin
      alloc_hit[r] = alloc_valid_i && (alloc_addr_i == ADDR_WIDTH'(r)) && addr_ok(alloc_addr_i);
      if (flush_i) begin
        busy_next[r] = 1'b0;
      end else if (alloc_hit[r]) begin
        busy_next[r] = 1'b1;
      end else if (wr_en[r]) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_WORDS; r++) begin
        mem_reg[r] <= '0;
      end
      busy_reg      <= '0;
      collision_reg <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_WORDS; r++) begin
        if (wr_en[r]) begin
          mem_reg[r] <= wr_data[r];
        end
      end
      busy_reg      <= busy_next;
      collision_reg <= collision_next;
    end
  end

  assign collision_o = collision_reg;

  generate
    for (gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] raddr;
      logic [DATA_WIDTH-1:0] data_c;
      logic                  busy_c;

      assign raddr = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Word mux by compare so non-power-of-two depths never index past the array.
      always_comb begin
        data_c = '0;
        busy_c = 1'b0;
        for (int r = 0; r < NUM_WORDS; r++) begin
          if ((raddr == ADDR_WIDTH'(r)) && addr_ok(raddr)) begin
            if ((BYPASS_EN != 0) && wr_en[r]) begin
              data_c = wr_data[r];
            end else begin
              data_c = mem_reg[r];
            end
            busy_c = (BYPASS_EN != 0) ? busy_next[r] : busy_reg[r];
          end
        end
      end

      if (READ_REGISTERED != 0) begin : g_reg
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  busy_out_reg;

        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            data_reg     <= '0;
            busy_out_reg <= 1'b0;
          end else begin
            data_reg     <= data_c;
            busy_out_reg <= busy_c;
          end
        end

        assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
        assign rbusy_o[gi]                          = busy_out_reg;
      end else begin : g_comb
        assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = data_c;
        assign rbusy_o[gi]                          = busy_c;
      end
    end
  endgenerate

endmodule
